// File: rtl/jpeg_lane_xor_cmp_if.sv
// Handshake bundle for the multi-lane XOR/XNOR comparator: operand stream in,
// per-lane result stream out, and the per-frame totals pulse.
interface jpeg_lane_xor_cmp_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   in_a;
    logic [LANES*WIDTH-1:0]   in_b;
    logic                     in_mode;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*WIDTH-1:0]   out_data;
    logic [LANES-1:0]         out_eq;
    logic                     out_last;
    logic                     frm_valid;
    logic [CNT_W-1:0]         frm_mism;
    logic [CNT_W-1:0]         frm_beats;

    modport master (
        output in_valid, in_a, in_b, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_eq, out_last,
        input  frm_valid, frm_mism, frm_beats
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_data, out_eq, out_last,
        output frm_valid, frm_mism, frm_beats
    );
endinterface

// File: rtl/jpeg_lane_xor_cmp.sv
// Two-stage multi-lane XOR/XNOR comparator. Stage 1 captures operands, stage 2
// holds the per-lane difference word and equality flags. Output handshakes
// feed saturating per-frame mismatch/beat accumulators reported on frm_*.
module jpeg_lane_xor_cmp #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    jpeg_lane_xor_cmp_if.slave bus
);
    localparam int DW    = LANES * WIDTH;
    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    // Number of lanes whose equality flag is clear.
    function automatic logic [PC_W-1:0] count_mism(input logic [LANES-1:0] eq);
        logic [PC_W-1:0] n;
        n = {PC_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (!eq[i]) begin
                n = n + PC_W'(1'b1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Add with clamp at the all-ones counter value; never wraps.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                input logic [PC_W-1:0]  inc);
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] lim;
        sum = SUM_W'(acc) + SUM_W'(inc);
        lim = SUM_W'({CNT_W{1'b1}});
        if (sum > lim) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    logic             s1_valid_r;
    logic [DW-1:0]    s1_a_r;
    logic [DW-1:0]    s1_b_r;
    logic             s1_mode_r;
    logic             s1_last_r;
    logic             out_valid_r;
    logic [DW-1:0]    out_data_r;
    logic [LANES-1:0] out_eq_r;
    logic             out_last_r;
    logic             frm_valid_r;
    logic [CNT_W-1:0] frm_mism_r;
    logic [CNT_W-1:0] frm_beats_r;
    logic [CNT_W-1:0] mism_acc_r;
    logic [CNT_W-1:0] beat_acc_r;

    logic             s2_en_s;
    logic             s1_en_s;
    logic             out_hs_s;
    logic [DW-1:0]    diff_s;
    logic [DW-1:0]    data_s;
    logic [LANES-1:0] eq_s;
    logic [CNT_W-1:0] mism_next_s;
    logic [CNT_W-1:0] beat_next_s;

    assign s2_en_s  = !out_valid_r || bus.out_ready;
    assign s1_en_s  = !s1_valid_r || s2_en_s;
    assign out_hs_s = out_valid_r && bus.out_ready;

    assign bus.in_ready  = s1_en_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_eq    = out_eq_r;
    assign bus.out_last  = out_last_r;
    assign bus.frm_valid = frm_valid_r;
    assign bus.frm_mism  = frm_mism_r;
    assign bus.frm_beats = frm_beats_r;

    // Per-lane difference word (mode applied) and mode-independent equality.
    always_comb begin
        diff_s = s1_a_r ^ s1_b_r;
        data_s = s1_mode_r ? ~diff_s : diff_s;
        eq_s   = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            eq_s[i] = (diff_s[i*WIDTH +: WIDTH] == {WIDTH{1'b0}});
        end
    end

    // Next accumulator values for the beat currently leaving the block.
    always_comb begin
        mism_next_s = sat_add(mism_acc_r, count_mism(out_eq_r));
        beat_next_s = sat_add(beat_acc_r, PC_W'(1'b1));
    end

    // Stage 1: capture operands whenever the stage can accept a beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {DW{1'b0}};
            s1_b_r     <= {DW{1'b0}};
            s1_mode_r  <= 1'b0;
            s1_last_r  <= 1'b0;
        end else if (s1_en_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_a_r    <= bus.in_a;
                s1_b_r    <= bus.in_b;
                s1_mode_r <= bus.in_mode;
                s1_last_r <= bus.in_last;
            end
        end
    end

    // Stage 2: registered result; holds stable while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DW{1'b0}};
            out_eq_r    <= {LANES{1'b0}};
            out_last_r  <= 1'b0;
        end else if (s2_en_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_data_r <= data_s;
                out_eq_r   <= eq_s;
                out_last_r <= s1_last_r;
            end
        end
    end

    // Frame accounting: accumulate on output handshake, publish on last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            frm_valid_r <= 1'b0;
            frm_mism_r  <= {CNT_W{1'b0}};
            frm_beats_r <= {CNT_W{1'b0}};
            mism_acc_r  <= {CNT_W{1'b0}};
            beat_acc_r  <= {CNT_W{1'b0}};
        end else begin
            frm_valid_r <= 1'b0;
            if (out_hs_s) begin
                if (out_last_r) begin
                    frm_valid_r <= 1'b1;
                    frm_mism_r  <= mism_next_s;
                    frm_beats_r <= beat_next_s;
                    mism_acc_r  <= {CNT_W{1'b0}};
                    beat_acc_r  <= {CNT_W{1'b0}};
                end else begin
                    mism_acc_r  <= mism_next_s;
                    beat_acc_r  <= beat_next_s;
                end
            end
        end
    end
endmodule

// File: tb/tb_jpeg_lane_xor_cmp.sv
// Bench for jpeg_lane_xor_cmp: directed scenarios plus a randomized stream
// checked against a lane-level arithmetic model and a frame-totals model.
`timescale 1ns/1ps
module tb_jpeg_lane_xor_cmp;
    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int CNT_W = 16;
    localparam int DW    = WIDTH * LANES;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          mode;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [LANES-1:0] eq;
        logic             last;
    } res_t;

    typedef struct packed {
        logic [CNT_W-1:0] mism;
        logic [CNT_W-1:0] beats;
    } frm_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jpeg_lane_xor_cmp_if #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) bus ();
    jpeg_lane_xor_cmp_if #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(2))     bus2 ();

    jpeg_lane_xor_cmp #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    jpeg_lane_xor_cmp #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    beat_t stim_q[$];
    res_t  cap_q[$];
    frm_t  frm_q[$];
    int    frm_cyc_q[$];
    frm_t  exp_frm_q[$];
    res_t  mon_r;
    frm_t  mon_f;

    // Cycle counter used to time-stamp frame pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every output handshake and every frame pulse.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                mon_r.data = bus.out_data;
                mon_r.eq   = bus.out_eq;
                mon_r.last = bus.out_last;
                cap_q.push_back(mon_r);
            end
            if (bus.frm_valid === 1'b1) begin
                mon_f.mism  = bus.frm_mism;
                mon_f.beats = bus.frm_beats;
                frm_q.push_back(mon_f);
                frm_cyc_q.push_back(cyc);
            end
        end
    end

    // Reference: each lane compared as an integer; XNOR is 255 minus XOR.
    function automatic res_t model_beat(input beat_t t);
        res_t r;
        int av, bv, x;
        r.last = t.last;
        r.eq   = '0;
        r.data = '0;
        for (int i = 0; i < LANES; i++) begin
            av = int'(t.a[8*i +: 8]);
            bv = int'(t.b[8*i +: 8]);
            x  = av ^ bv;
            if (t.mode) x = 255 - x;
            r.data[8*i +: 8] = x[7:0];
            r.eq[i]          = (av == bv);
        end
        return r;
    endfunction

    // Reference frame totals over stim_q with clamp at maxv.
    task automatic build_exp_frames(input int maxv);
        int beats, mism, ne;
        beats = 0;
        mism  = 0;
        exp_frm_q.delete();
        foreach (stim_q[i]) begin
            ne = 0;
            for (int l = 0; l < LANES; l++)
                if (stim_q[i].a[8*l +: 8] != stim_q[i].b[8*l +: 8]) ne++;
            beats = (beats + 1 > maxv) ? maxv : beats + 1;
            mism  = (mism + ne > maxv) ? maxv : mism + ne;
            if (stim_q[i].last) begin
                exp_frm_q.push_back({CNT_W'(mism), CNT_W'(beats)});
                beats = 0;
                mism  = 0;
            end
        end
    endtask

    function automatic beat_t rand_beat(input bit last);
        beat_t t;
        t.a = $urandom;
        t.b = t.a;
        for (int i = 0; i < LANES; i++)
            if ($urandom_range(0, 1) == 1) t.b[8*i +: 8] = 8'($urandom);
        t.mode = 1'($urandom_range(0, 1));
        t.last = last;
        return t;
    endfunction

    function automatic beat_t mk_beat(input logic [DW-1:0] a, input logic [DW-1:0] flip,
                                      input bit last);
        beat_t t;
        t.a    = a;
        t.b    = a ^ flip;
        t.mode = 1'($urandom_range(0, 1));
        t.last = last;
        return t;
    endfunction

    // Drive stim_q from index start; optional random valid gaps and backpressure.
    task automatic push_stream(input bit rnd, input int start);
        int k, guard;
        bit acc;
        k = start;
        guard = 0;
        while (k < stim_q.size() && guard < 5000) begin
            bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd && $urandom_range(0, 4) == 0) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_a     = stim_q[k].a;
                bus.in_b     = stim_q[k].b;
                bus.in_mode  = stim_q[k].mode;
                bus.in_last  = stim_q[k].last;
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) k++;
            guard++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_checks++;
        if (k !== stim_q.size()) $display("FAIL accept_timeout accepted %0d required %0d", k, stim_q.size());
        else n_pass++;
        guard = 0;
        while (cap_q.size() < stim_q.size() && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        stim_q.delete();
        cap_q.delete();
        frm_q.delete();
        frm_cyc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_mode = 1'b0; bus.in_last = 1'b0;
        bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_mode = 1'b0; bus2.in_last = 1'b0;
        bus2.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.frm_valid, bus.out_last} !== 4'b1000)
            $display("FAIL reset_flags got %b required 1000",
                     {bus.in_ready, bus.out_valid, bus.frm_valid, bus.out_last});
        else n_pass++;
        n_checks++;
        if ({bus.out_data, bus.out_eq, bus.frm_mism, bus.frm_beats} !== '0)
            $display("FAIL reset_values data=%h eq=%b mism=%0d beats=%0d required all zero",
                     bus.out_data, bus.out_eq, bus.frm_mism, bus.frm_beats);
        else n_pass++;
        clear_queues();
    endtask

    // Single-beat frames in XOR then XNOR mode: latency, values, pulse timing.
    task automatic test_basic();
        logic [DW-1:0] exp_data [2];
        exp_data[0] = 32'h00CB0078;
        exp_data[1] = 32'hFF34FF87;
        for (int m = 0; m < 2; m++) begin
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            bus.in_valid  = 1'b1;
            bus.in_a      = 32'h12345678;
            bus.in_b      = 32'h12FF5600;
            bus.in_mode   = 1'(m);
            bus.in_last   = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b0) $display("FAIL basic_latency m%0d out_valid=%b required 0", m, bus.out_valid);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({bus.out_valid, bus.out_data, bus.out_eq, bus.out_last} !== {1'b1, exp_data[m], 4'b1010, 1'b1})
                $display("FAIL basic_out m%0d valid=%b data=%h eq=%b last=%b required 1 %h 1010 1",
                         m, bus.out_valid, bus.out_data, bus.out_eq, bus.out_last, exp_data[m]);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({bus.frm_valid, bus.frm_mism, bus.frm_beats} !== {1'b1, 16'd2, 16'd1})
                $display("FAIL basic_frame m%0d valid=%b mism=%0d beats=%0d required 1 2 1",
                         m, bus.frm_valid, bus.frm_mism, bus.frm_beats);
            else n_pass++;
            @(negedge clk);
            n_checks++;
            if ({bus.frm_valid, bus.frm_mism, bus.frm_beats} !== {1'b0, 16'd2, 16'd1})
                $display("FAIL basic_pulse_hold m%0d valid=%b mism=%0d beats=%0d required 0 2 1",
                         m, bus.frm_valid, bus.frm_mism, bus.frm_beats);
            else n_pass++;
        end
        @(posedge clk); #1;
        clear_queues();
    endtask

    // Five beats against a stalled output, then release.
    task automatic test_stall();
        int k;
        bit acc, first, unstable, last_ready;
        logic [DW-1:0] held;
        clear_queues();
        for (int i = 0; i < 5; i++) stim_q.push_back(rand_beat(i == 4));
        k = 0; first = 1'b1; unstable = 1'b0; last_ready = 1'b1; held = '0;
        for (int c = 0; c < 6; c++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = (k < 5);
            if (k < 5) begin
                bus.in_a = stim_q[k].a; bus.in_b = stim_q[k].b;
                bus.in_mode = stim_q[k].mode; bus.in_last = stim_q[k].last;
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            last_ready = bus.in_ready;
            if (bus.out_valid) begin
                if (first) begin held = bus.out_data; first = 1'b0; end
                else if (bus.out_data !== held) unstable = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) k++;
        end
        n_checks++;
        if (k !== 2 || last_ready !== 1'b0)
            $display("FAIL stall_accept accepted=%0d in_ready=%b required 2 0", k, last_ready);
        else n_pass++;
        n_checks++;
        if (unstable || first || held !== model_beat(stim_q[0]).data)
            $display("FAIL stall_hold held=%h unstable=%b required %h stable", held, unstable,
                     model_beat(stim_q[0]).data);
        else n_pass++;
        push_stream(1'b0, k);
        n_checks++;
        if (cap_q.size() !== 5) $display("FAIL stall_count got %0d required 5", cap_q.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== model_beat(stim_q[i]))
                $display("FAIL stall_beat%0d got %h required %h", i, cap_q[i], model_beat(stim_q[i]));
            else n_pass++;
        end
    endtask

    // Multi-beat frame totals, restart from zero, back-to-back single-beat frames.
    task automatic test_frames();
        frm_t want [4];
        clear_queues();
        stim_q.push_back(mk_beat($urandom, 32'h00000000, 1'b0));
        stim_q.push_back(mk_beat($urandom, 32'h80402010, 1'b0));
        stim_q.push_back(mk_beat($urandom, 32'h00000100, 1'b1));
        stim_q.push_back(mk_beat($urandom, 32'h01000001, 1'b1));
        stim_q.push_back(mk_beat($urandom, 32'h00000000, 1'b1));
        stim_q.push_back(mk_beat($urandom, 32'hFFFFFFFF, 1'b1));
        want[0] = {16'd5, 16'd3};
        want[1] = {16'd2, 16'd1};
        want[2] = {16'd0, 16'd1};
        want[3] = {16'd4, 16'd1};
        push_stream(1'b0, 0);
        n_checks++;
        if (frm_q.size() !== 4) $display("FAIL frames_count got %0d required 4", frm_q.size());
        else n_pass++;
        for (int i = 0; i < 4 && i < frm_q.size(); i++) begin
            n_checks++;
            if (frm_q[i] !== want[i])
                $display("FAIL frames_totals%0d mism=%0d beats=%0d required %0d %0d", i,
                         frm_q[i].mism, frm_q[i].beats, want[i].mism, want[i].beats);
            else n_pass++;
        end
        if (frm_cyc_q.size() == 4) begin
            n_checks++;
            if (frm_cyc_q[2] - frm_cyc_q[1] !== 1 || frm_cyc_q[3] - frm_cyc_q[2] !== 1)
                $display("FAIL frames_back_to_back gaps %0d %0d required 1 1",
                         frm_cyc_q[2] - frm_cyc_q[1], frm_cyc_q[3] - frm_cyc_q[2]);
            else n_pass++;
        end
    endtask

    // Randomized stream with gaps and backpressure against both models.
    task automatic test_random();
        clear_queues();
        for (int i = 0; i < 80; i++) stim_q.push_back(rand_beat(i == 79 || $urandom_range(0, 3) == 0));
        build_exp_frames(65535);
        push_stream(1'b1, 0);
        n_checks++;
        if (cap_q.size() !== stim_q.size())
            $display("FAIL random_count got %0d required %0d", cap_q.size(), stim_q.size());
        else n_pass++;
        for (int i = 0; i < stim_q.size() && i < cap_q.size(); i++) begin
            n_checks++;
            if (cap_q[i] !== model_beat(stim_q[i]))
                $display("FAIL random_beat%0d got %h required %h", i, cap_q[i], model_beat(stim_q[i]));
            else n_pass++;
        end
        n_checks++;
        if (frm_q.size() !== exp_frm_q.size())
            $display("FAIL random_frame_count got %0d required %0d", frm_q.size(), exp_frm_q.size());
        else n_pass++;
        for (int i = 0; i < exp_frm_q.size() && i < frm_q.size(); i++) begin
            n_checks++;
            if (frm_q[i] !== exp_frm_q[i])
                $display("FAIL random_frame%0d got %h required %h", i, frm_q[i], exp_frm_q[i]);
            else n_pass++;
        end
    endtask

    // Reset during an open, stalled frame discards it entirely.
    task automatic test_reset_midframe();
        clear_queues();
        stim_q.push_back(rand_beat(1'b0));
        stim_q.push_back(rand_beat(1'b0));
        push_stream(1'b0, 0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_last   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.frm_valid, bus.out_data} !== {3'b100, 32'h0})
            $display("FAIL midreset_state in_ready=%b out_valid=%b frm_valid=%b data=%h required 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.frm_valid, bus.out_data);
        else n_pass++;
        @(posedge clk); #1;
        clear_queues();
        stim_q.push_back(mk_beat($urandom, 32'h00200000, 1'b1));
        push_stream(1'b0, 0);
        n_checks++;
        if (frm_q.size() !== 1 || cap_q.size() !== 1)
            $display("FAIL midreset_counts pulses=%0d beats=%0d required 1 1", frm_q.size(), cap_q.size());
        else n_pass++;
        if (frm_q.size() > 0) begin
            n_checks++;
            if (frm_q[0] !== {16'd1, 16'd1})
                $display("FAIL midreset_totals mism=%0d beats=%0d required 1 1", frm_q[0].mism, frm_q[0].beats);
            else n_pass++;
        end
    endtask

    // Narrow counters clamp at 3 on the CNT_W=2 instance.
    task automatic test_saturation();
        bit seen;
        logic [1:0] sm, sb;
        logic [DW-1:0] a;
        for (int i = 0; i < 5; i++) begin
            a = $urandom;
            bus2.in_valid = 1'b1;
            bus2.in_a     = a;
            bus2.in_b     = ~a;
            bus2.in_mode  = 1'($urandom_range(0, 1));
            bus2.in_last  = (i == 4);
            @(posedge clk); #1;
        end
        bus2.in_valid = 1'b0;
        seen = 1'b0; sm = 2'd0; sb = 2'd0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus2.frm_valid === 1'b1) begin seen = 1'b1; sm = bus2.frm_mism; sb = bus2.frm_beats; end
        end
        n_checks++;
        if (!seen || sm !== 2'd3 || sb !== 2'd3)
            $display("FAIL saturate seen=%b mism=%0d beats=%0d required 1 3 3", seen, sm, sb);
        else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_frames();
        test_random();
        test_reset_midframe();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
